// File: rtl/mem_responder.sv
// Target side of the core's MEM_* bus: single-transfer byte/word accesses to an
// internal little-endian RAM, completing a fixed LATENCY cycles after acceptance.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_exec,
  input  logic        I_write,
  input  logic [1:0]  I_size,
  input  logic [15:0] I_addr,
  input  logic [15:0] I_data,
  output logic        O_ready,
  output logic [15:0] O_data,
  output logic        O_data_ready
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] LastCnt = 4'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_hi;
  logic [15:0]             wdata_q;
  logic [15:0]             rdata;
  logic                    accept;
  logic                    done;

  logic [7:0] mem [2**ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (I_exec) begin
          accept  = 1'b1;
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (cnt_q == LastCnt) begin
          done    = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign O_ready = (state_q == StIdle);

  // Word high byte wraps within the decoded address space.
  assign addr_hi = addr_q + ADDR_WIDTH'(1);

  always_comb begin
    rdata = '0;
    case (size_q)
      2'd1:    rdata = {8'h00, mem[addr_q]};
      2'd2:    rdata = {mem[addr_hi], mem[addr_q]};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      O_data       <= '0;
      O_data_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      O_data_ready <= done && !wr_q;
      if (accept) begin
        wr_q    <= I_write;
        size_q  <= I_size;
        addr_q  <= I_addr[ADDR_WIDTH-1:0];
        wdata_q <= I_data;
      end
      if (done && !wr_q) begin
        O_data <= rdata;
      end
    end
  end

  // RAM is not reset; done is low while reset holds the FSM idle, so aborted writes never land.
  always_ff @(posedge I_clk) begin
    if (done && wr_q) begin
      if (size_q == 2'd1) begin
        mem[addr_q] <= wdata_q[7:0];
      end else if (size_q == 2'd2) begin
        mem[addr_q]  <= wdata_q[7:0];
        mem[addr_hi] <= wdata_q[15:8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (LATENCY 2, 1, 15) share
// request fields; each has its own strobe.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  exec;
  logic        write;
  logic [1:0]  size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [2:0]  rdy;
  logic [2:0]  dr;
  logic [15:0] dat [3];

  int checks = 0;
  int errors = 0;
  logic [15:0] sbq [$];

  mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
    .I_clk(clk), .I_reset(rst), .I_exec(exec[0]), .I_write(write), .I_size(size),
    .I_addr(addr), .I_data(wdata), .O_ready(rdy[0]), .O_data(dat[0]), .O_data_ready(dr[0])
  );

  mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut_l1 (
    .I_clk(clk), .I_reset(rst), .I_exec(exec[1]), .I_write(write), .I_size(size),
    .I_addr(addr), .I_data(wdata), .O_ready(rdy[1]), .O_data(dat[1]), .O_data_ready(dr[1])
  );

  mem_responder #(.ADDR_WIDTH(12), .LATENCY(15)) dut_l15 (
    .I_clk(clk), .I_reset(rst), .I_exec(exec[2]), .I_write(write), .I_size(size),
    .I_addr(addr), .I_data(wdata), .O_ready(rdy[2]), .O_data(dat[2]), .O_data_ready(dr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer on instance u; reads push their expected data to the scoreboard.
  task automatic txn(input int u, input int lat, input logic wr, input logic [1:0] sz,
                     input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_rd,
                     input string name);
    int n;
    logic [15:0] e;
    logic [15:0] prev;
    prev = dat[u];
    if (!wr) sbq.push_back(exp_rd);
    exec[u] = 1'b1;
    write   = wr;
    size    = sz;
    addr    = a;
    wdata   = d;
    tick();
    exec[u] = 1'b0;
    write   = 1'($urandom);
    size    = 2'($urandom);
    addr    = 16'($urandom);
    wdata   = 16'($urandom);
    checks++;
    if (rdy[u] !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_ready: got %b want 0", name, rdy[u]);
    end
    n = 0;
    while (rdy[u] !== 1'b1 && n < 40) begin
      if (dr[u] !== 1'b0) begin
        errors++;
        $display("FAIL %s early_data_ready: got %b want 0 at cycle %0d", name, dr[u], n);
      end
      tick();
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, lat);
    end
    checks++;
    if (dr[u] !== !wr) begin
      errors++;
      $display("FAIL %s data_ready_at_completion: got %b want %b", name, dr[u], !wr);
    end
    if (!wr) begin
      e = sbq.pop_front();
      checks++;
      if (dat[u] !== e) begin
        errors++;
        $display("FAIL %s read_data: got %h want %h", name, dat[u], e);
      end
    end
    tick();
    checks++;
    if (dr[u] !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: got %b want 0", name, dr[u]);
    end
    if (wr) begin
      checks++;
      if (dat[u] !== prev) begin
        errors++;
        $display("FAIL %s write_keeps_data: got %h want %h", name, dat[u], prev);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    exec  = '0;
    write = 1'b0;
    size  = 2'd0;
    addr  = '0;
    wdata = '0;
    tick();
    tick();
    checks++;
    if (rdy !== 3'b111 || dr !== 3'b000) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b data_ready=%b want 111 000", rdy, dr);
    end
    checks++;
    if (dat[0] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h want 0000", dat[0]);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    txn(0, 2, 1'b1, 2'd2, 16'h0010, 16'h0000, 16'h0000, "prewrite");
    exec[0] = 1'b1;
    write   = 1'b1;
    size    = 2'd2;
    addr    = 16'h0010;
    wdata   = 16'hBEEF;
    tick();
    exec[0] = 1'b0;
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_accepted: got ready=%b want 0", rdy[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy[0] !== 1'b1 || dr[0] !== 1'b0 || dat[0] !== 16'h0000) begin
      errors++;
      $display("FAIL abort_outputs: got ready=%b dr=%b data=%h want 1 0 0000",
               rdy[0], dr[0], dat[0]);
    end
    tick();
    rst = 1'b0;
    tick();
    txn(0, 2, 1'b0, 2'd2, 16'h0010, 16'h0000, 16'h0000, "abort_readback");
  endtask

  task automatic test_word_byte();
    txn(0, 2, 1'b1, 2'd2, 16'h0020, 16'h1234, 16'h0000, "word_write");
    txn(0, 2, 1'b0, 2'd2, 16'h0020, 16'h0000, 16'h1234, "word_read");
    txn(0, 2, 1'b1, 2'd1, 16'h0021, 16'h55AB, 16'h0000, "byte_write");
    txn(0, 2, 1'b0, 2'd2, 16'h0020, 16'h0000, 16'hAB34, "word_after_byte");
    txn(0, 2, 1'b0, 2'd1, 16'h0020, 16'h0000, 16'h0034, "byte_read");
  endtask

  task automatic test_wrap();
    txn(0, 2, 1'b1, 2'd2, 16'h0FFF, 16'hCAFE, 16'h0000, "wrap_write");
    txn(0, 2, 1'b0, 2'd1, 16'h0000, 16'h0000, 16'h00CA, "wrap_byte0");
    txn(0, 2, 1'b0, 2'd1, 16'h1FFF, 16'h0000, 16'h00FE, "alias_read");
    txn(0, 2, 1'b0, 2'd2, 16'hFFFF, 16'h0000, 16'hCAFE, "wrap_word_read");
  endtask

  task automatic test_busy_ignore();
    int pulses;
    logic [15:0] e;
    pulses = 0;
    sbq.push_back(16'hAB34);
    exec[0] = 1'b1;
    write   = 1'b0;
    size    = 2'd2;
    addr    = 16'h0020;
    tick();
    addr    = 16'h0FFF;
    size    = 2'd1;
    tick();
    exec[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dr[0] === 1'b1) begin
        pulses++;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checks++;
          if (dat[0] !== e) begin
            errors++;
            $display("FAIL busy_ignore_data: got %h want %h", dat[0], e);
          end
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL busy_ignore_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_idle: got ready=%b want 1", rdy[0]);
    end
  endtask

  task automatic test_illegal_size();
    txn(0, 2, 1'b0, 2'd3, 16'h0020, 16'h0000, 16'h0000, "size3_read");
    txn(0, 2, 1'b1, 2'd0, 16'h0020, 16'h5555, 16'h0000, "size0_write");
    txn(0, 2, 1'b1, 2'd3, 16'h0020, 16'h6666, 16'h0000, "size3_write");
    txn(0, 2, 1'b0, 2'd2, 16'h0020, 16'h0000, 16'hAB34, "illegal_unchanged");
  endtask

  task automatic test_latency();
    txn(1, 1, 1'b1, 2'd2, 16'h0020, 16'h1234, 16'h0000, "l1_write");
    txn(1, 1, 1'b0, 2'd2, 16'h0020, 16'h0000, 16'h1234, "l1_read");
    txn(2, 15, 1'b1, 2'd2, 16'h0020, 16'h1234, 16'h0000, "l15_write");
    txn(2, 15, 1'b0, 2'd2, 16'h0020, 16'h0000, 16'h1234, "l15_read");
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_word_byte();
    test_wrap();
    test_busy_ignore();
    test_illegal_size();
    test_latency();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
